// File: rtl/rom_arb_pkg.sv
// Shared types for the cartridge ROM port arbiter.
// State and owner enums plus the data returned on an aborted access.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_COP
  } owner_e;

  localparam logic [15:0] Q_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/rom_arb_line_cache.sv
// One-entry CPU read cache: word tag, valid bit and 16-bit data.
// A flush in the same cycle as a fill wins, leaving the entry invalid.
module rom_arb_line_cache
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              fill_i,
  input  logic [ADDR_W-2:0] fill_tag_i,
  input  logic [15:0]       fill_data_i,
  input  logic [ADDR_W-2:0] look_tag_i,
  output logic              hit_o,
  output logic [15:0]       data_o
);

  logic              valid_q;
  logic [ADDR_W-2:0] tag_q;
  logic [15:0]       data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (fill_i) begin
        valid_q <= 1'b1;
        tag_q   <= fill_tag_i;
        data_q  <= fill_data_i;
      end
      if (flush_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign hit_o  = valid_q && (tag_q == look_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the cartridge ROM port between CPU and coprocessor fetch paths.
// Define ROM_ARB_CACHE_EN to add a one-entry CPU read cache.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 63
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_word,
  output logic              cpu_ack,
  output logic [15:0]       cpu_q,
  input  logic              cop_req,
  input  logic [ADDR_W-1:0] cop_addr,
  input  logic              cop_word,
  output logic              cop_ack,
  output logic [15:0]       cop_q,
  input  logic              cfg_flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_word,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  input  logic              mem_ack,
  input  logic [15:0]       mem_q,
  output logic              timeout
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              word_q, word_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cop_ack_q, cop_ack_d;
  logic [15:0]       cpu_q_q, cpu_q_d;
  logic [15:0]       cop_q_q, cop_q_d;
  logic              tmo_q, tmo_d;

  logic        ack_busy;
  logic        cpu_eff;
  logic        cop_eff;
  logic        cop_win;
  logic        cpu_win;
  logic        hit;
  logic [15:0] hit_data;

`ifdef ROM_ARB_CACHE_EN
  logic fill;

  assign fill = (state_q == WAIT) && mem_ack && (owner_q == OWN_CPU);

  rom_arb_line_cache #(
    .ADDR_W(ADDR_W)
  ) u_cache (
    .clk_i      (mclk),
    .rst_i      (rst),
    .flush_i    (cfg_flush),
    .fill_i     (fill),
    .fill_tag_i (addr_q[ADDR_W-1:1]),
    .fill_data_i(mem_q),
    .look_tag_i (cpu_addr[ADDR_W-1:1]),
    .hit_o      (hit),
    .data_o     (hit_data)
  );
`else
  logic unused_flush;

  assign unused_flush = cfg_flush;
  assign hit          = 1'b0;
  assign hit_data     = 16'h0000;
`endif

  // The ack cycle is not a grant slot: a held req then is the finished one.
  assign ack_busy = cpu_ack_q | cop_ack_q;
  assign cpu_eff  = cpu_req && !ack_busy;
  assign cop_eff  = cop_req && !ack_busy;
  assign cop_win  = cop_eff && (!cpu_eff || starve_q == STARVE_MAX);
  assign cpu_win  = cpu_eff && !cop_win;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    word_d    = word_q;
    cpu_q_d   = cpu_q_q;
    cop_q_d   = cop_q_q;
    cpu_ack_d = 1'b0;
    cop_ack_d = 1'b0;
    tmo_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cop_win) begin
          owner_d  = OWN_COP;
          addr_d   = cop_addr;
          word_d   = cop_word;
          starve_d = '0;
          state_d  = ISSUE;
        end else if (cpu_win && hit) begin
          cpu_ack_d = 1'b1;
          cpu_q_d   = hit_data;
        end else if (cpu_win) begin
          owner_d = OWN_CPU;
          addr_d  = cpu_addr;
          word_d  = cpu_word;
          state_d = ISSUE;
          if (cop_eff && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (owner_q == OWN_CPU) begin
            cpu_ack_d = 1'b1;
            cpu_q_d   = mem_q;
          end else begin
            cop_ack_d = 1'b1;
            cop_q_d   = mem_q;
          end
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          if (owner_q == OWN_CPU) begin
            cpu_ack_d = 1'b1;
            cpu_q_d   = Q_TIMEOUT;
          end else begin
            cop_ack_d = 1'b1;
            cop_q_d   = Q_TIMEOUT;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_CPU;
      starve_q  <= '0;
      wcnt_q    <= '0;
      addr_q    <= '0;
      word_q    <= 1'b0;
      cpu_ack_q <= 1'b0;
      cop_ack_q <= 1'b0;
      cpu_q_q   <= '0;
      cop_q_q   <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      cpu_ack_q <= cpu_ack_d;
      cop_ack_q <= cop_ack_d;
      cpu_q_q   <= cpu_q_d;
      cop_q_q   <= cop_q_d;
      tmo_q     <= tmo_d;
    end
  end

  assign mem_req  = (state_q == ISSUE);
  assign mem_ce_n = !(state_q == ISSUE || state_q == WAIT);
  assign mem_oe_n = !(state_q == ISSUE || state_q == WAIT);
  assign mem_addr = addr_q;
  assign mem_word = word_q;
  assign cpu_ack  = cpu_ack_q;
  assign cop_ack  = cop_ack_q;
  assign cpu_q    = cpu_q_q;
  assign cop_q    = cop_q_q;
  assign timeout  = tmo_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter.
// Cache scenario changes expectation when ROM_ARB_CACHE_EN is defined.
module tb_rom_port_arbiter;

  logic        mclk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_word, cpu_ack;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_q;
  logic        cop_req, cop_word, cop_ack;
  logic [23:0] cop_addr;
  logic [15:0] cop_q;
  logic        cfg_flush;
  logic        mem_req, mem_word, mem_ce_n, mem_oe_n;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_q;
  logic        timeout;

  int checks = 0;
  int passes = 0;
  int n_memreq = 0;
  int n_cpuack = 0;

  rom_port_arbiter dut (
    .mclk     (mclk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_word (cpu_word),
    .cpu_ack  (cpu_ack),
    .cpu_q    (cpu_q),
    .cop_req  (cop_req),
    .cop_addr (cop_addr),
    .cop_word (cop_word),
    .cop_ack  (cop_ack),
    .cop_q    (cop_q),
    .cfg_flush(cfg_flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_word (mem_word),
    .mem_ce_n (mem_ce_n),
    .mem_oe_n (mem_oe_n),
    .mem_ack  (mem_ack),
    .mem_q    (mem_q),
    .timeout  (timeout)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) begin
    if (mem_req === 1'b1) n_memreq++;
    if (cpu_ack === 1'b1) n_cpuack++;
  end

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_req = 0; cpu_addr = '0; cpu_word = 0;
    cop_req = 0; cop_addr = '0; cop_word = 0;
    cfg_flush = 0; mem_ack = 0; mem_q = '0;
    tick(); tick();
    checks++;
    if ({mem_req, cpu_ack, cop_ack, timeout} !== 4'b0000)
      $display("FAIL reset_pulses: got %b exp 0000",
               {mem_req, cpu_ack, cop_ack, timeout});
    else passes++;
    checks++;
    if ({mem_ce_n, mem_oe_n} !== 2'b11)
      $display("FAIL reset_ce_oe: got %b exp 11", {mem_ce_n, mem_oe_n});
    else passes++;
    checks++;
    if ({mem_addr, mem_word, cpu_q, cop_q} !== 57'd0)
      $display("FAIL reset_data: addr %h word %b cpu_q %h cop_q %h exp 0",
               mem_addr, mem_word, cpu_q, cop_q);
    else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_cpu;
    int base;
    base = n_memreq;
    cpu_req = 1; cpu_addr = 24'h008000; cpu_word = 1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 24'h008000 || mem_ce_n !== 1'b0)
      $display("FAIL basic_issue: req %b addr %h ce_n %b exp 1 008000 0",
               mem_req, mem_addr, mem_ce_n);
    else passes++;
    tick();
    checks++;
    if (mem_req !== 1'b0 || mem_oe_n !== 1'b0)
      $display("FAIL basic_wait: req %b oe_n %b exp 0 0", mem_req, mem_oe_n);
    else passes++;
    tick();
    mem_ack = 1; mem_q = 16'hA55A;
    tick();
    mem_ack = 0;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_q !== 16'hA55A)
      $display("FAIL basic_ack: ack %b q %h exp 1 a55a", cpu_ack, cpu_q);
    else passes++;
    cpu_req = 0;
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || mem_ce_n !== 1'b1 || n_memreq - base !== 1)
      $display("FAIL basic_after: ack %b ce_n %b memreqs %0d exp 0 1 1",
               cpu_ack, mem_ce_n, n_memreq - base);
    else passes++;
  endtask

  task automatic test_starve;
    logic exp_cop;
    cfg_flush = 1;
    cpu_req = 1; cpu_addr = 24'h00A000; cpu_word = 1;
    cop_req = 1; cop_addr = 24'h40B000; cop_word = 0;
    for (int i = 0; i < 6; i++) begin
      exp_cop = (i == 4);
      for (int k = 0; k < 8; k++) begin
        if (mem_req === 1'b1) break;
        tick();
      end
      checks++;
      if (mem_req !== 1'b1 ||
          mem_addr !== (exp_cop ? 24'h40B000 : 24'h00A000))
        $display("FAIL starve_grant%0d: req %b addr %h exp cop=%b",
                 i, mem_req, mem_addr, exp_cop);
      else passes++;
      tick();
      mem_ack = 1; mem_q = 16'h0100 + 16'(i);
      tick();
      mem_ack = 0;
      checks++;
      if (cpu_ack !== !exp_cop || cop_ack !== exp_cop ||
          (exp_cop ? cop_q : cpu_q) !== 16'h0100 + 16'(i))
        $display("FAIL starve_ack%0d: cpu_ack %b cop_ack %b exp cop=%b",
                 i, cpu_ack, cop_ack, exp_cop);
      else passes++;
      if (i == 5) begin
        cpu_req = 0; cop_req = 0;
      end
    end
    cfg_flush = 0;
    tick();
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    cop_req = 1; cop_addr = 24'h300000; cop_word = 1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 24'h300000)
      $display("FAIL tmo_issue: req %b addr %h exp 1 300000", mem_req, mem_addr);
    else passes++;
    tick();
    for (int k = 0; k < 62; k++) begin
      tick();
      if (timeout === 1'b1 || cop_ack === 1'b1) early++;
    end
    checks++;
    if (early != 0)
      $display("FAIL tmo_early: %0d early pulses exp 0", early);
    else passes++;
    tick();
    checks++;
    if (timeout !== 1'b1 || cop_ack !== 1'b1 || cop_q !== 16'hFFFF)
      $display("FAIL tmo_fire: tmo %b ack %b q %h exp 1 1 ffff",
               timeout, cop_ack, cop_q);
    else passes++;
    cop_req = 0;
    tick();
    mem_ack = 1; mem_q = 16'h1111;
    tick();
    mem_ack = 0;
    tick();
    checks++;
    if (cop_ack !== 1'b0 || cpu_ack !== 1'b0 || cop_q !== 16'hFFFF ||
        timeout !== 1'b0)
      $display("FAIL tmo_late: ack %b/%b q %h tmo %b exp 0/0 ffff 0",
               cpu_ack, cop_ack, cop_q, timeout);
    else passes++;
  endtask

  task automatic test_drop_in_issue;
    int base_ack, base_req;
    base_ack = n_cpuack;
    base_req = n_memreq;
    cpu_req = 1; cpu_addr = 24'h00E000; cpu_word = 0;
    tick();
    cpu_req = 0;
    tick();
    mem_ack = 1; mem_q = 16'h1357;
    tick();
    mem_ack = 0;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_q !== 16'h1357)
      $display("FAIL drop_ack: ack %b q %h exp 1 1357", cpu_ack, cpu_q);
    else passes++;
    tick(); tick(); tick();
    checks++;
    if (n_cpuack - base_ack !== 1 || n_memreq - base_req !== 1)
      $display("FAIL drop_count: acks %0d memreqs %0d exp 1 1",
               n_cpuack - base_ack, n_memreq - base_req);
    else passes++;
  endtask

  task automatic test_cache;
    cpu_req = 1; cpu_addr = 24'h001234; cpu_word = 1;
    tick(); tick();
    mem_ack = 1; mem_q = 16'hBEEF;
    tick();
    mem_ack = 0;
    cpu_req = 0;
    tick();
    cpu_req = 1; cpu_addr = 24'h001235; cpu_word = 0;
    tick();
`ifdef ROM_ARB_CACHE_EN
    checks++;
    if (cpu_ack !== 1'b1 || cpu_q !== 16'hBEEF || mem_req !== 1'b0)
      $display("FAIL cache_hit: ack %b q %h req %b exp 1 beef 0",
               cpu_ack, cpu_q, mem_req);
    else passes++;
    cpu_req = 0;
    tick();
    cfg_flush = 1;
    tick();
    cfg_flush = 0;
    cpu_req = 1;
    tick();
`endif
    checks++;
    if (mem_req !== 1'b1 || cpu_ack !== 1'b0 || mem_addr !== 24'h001235)
      $display("FAIL cache_miss: req %b ack %b addr %h exp 1 0 001235",
               mem_req, cpu_ack, mem_addr);
    else passes++;
    tick();
    mem_ack = 1; mem_q = 16'h00C3;
    tick();
    mem_ack = 0;
    cpu_req = 0;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_q !== 16'h00C3)
      $display("FAIL cache_refill: ack %b q %h exp 1 00c3", cpu_ack, cpu_q);
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid;
    cpu_req = 1; cpu_addr = 24'h00D000; cpu_word = 1;
    tick(); tick();
    checks++;
    if (mem_ce_n !== 1'b0)
      $display("FAIL rstmid_wait: ce_n %b exp 0", mem_ce_n);
    else passes++;
    rst = 1;
    tick();
    checks++;
    if (mem_ce_n !== 1'b1 || mem_oe_n !== 1'b1 || cpu_ack !== 1'b0)
      $display("FAIL rstmid_abort: ce_n %b oe_n %b ack %b exp 1 1 0",
               mem_ce_n, mem_oe_n, cpu_ack);
    else passes++;
    cpu_req = 0;
    rst = 0;
    mem_ack = 1; mem_q = 16'h7777;
    tick();
    mem_ack = 0;
    checks++;
    if (cpu_ack !== 1'b0 || cpu_q !== 16'h0000 || mem_req !== 1'b0)
      $display("FAIL rstmid_late: ack %b q %h req %b exp 0 0000 0",
               cpu_ack, cpu_q, mem_req);
    else passes++;
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || mem_ce_n !== 1'b1)
      $display("FAIL rstmid_idle: ack %b ce_n %b exp 0 1", cpu_ack, mem_ce_n);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_cpu();
    test_starve();
    test_timeout();
    test_drop_in_issue();
    test_cache();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
